// File: rtl/dpll_acq_ctrl.sv
// dpll_acq_ctrl -- acquisition / lock supervisor for a digital PLL.
//
// Watches the phase-detector error stream and steps the loop filter from
// coarse through medium to fine gain until the loop stays in lock. It also
// drops back when lock is lost, and restarts acquisition if it takes too long.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   controller enable (0 forces IDLE and clears all counters)
//   ref_ok   in   reference activity present
//   err_vld  in   one-cycle strobe qualifying err
//   err      in   signed phase error, ERR_W bits
//   gain_sel out  loop-filter gain: 0 off, 1 coarse, 2 medium, 3 fine
//   dco_hold out  freeze DCO control word
//   locked   out  lock indication
//   state    out  state encoding: IDLE=0 COARSE=1 FINE=2 LOCKED=3 HOLDOVER=4
//   acq_fail out  one-cycle pulse on acquisition timeout
//
// Configuration
//   DPLL_HOLDOVER_EN  when defined, losing the reference while LOCKED enters
//                     HOLDOVER (DCO frozen) instead of IDLE, and returns to
//                     FINE once the reference comes back.
//
// All outputs are registered and change the cycle after the input that
// causes the change.

module dpll_acq_ctrl #(
  parameter int ERR_W      = 8,
  parameter int COARSE_THR = 16,
  parameter int LOCK_THR   = 4,
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_CNT = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ref_ok,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] err,
  output logic [1:0]              gain_sel,
  output logic                    dco_hold,
  output logic                    locked,
  output logic [2:0]              state,
  output logic                    acq_fail
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COARSE   = 3'd1,
    FINE     = 3'd2,
    LOCKED   = 3'd3,
    HOLDOVER = 3'd4
  } state_t;

  localparam logic [31:0] COARSE_LIM  = 32'(COARSE_THR);
  localparam logic [31:0] LOCK_LIM    = 32'(LOCK_THR);
  localparam logic [31:0] LOCK_N      = 32'(LOCK_CNT);
  localparam logic [31:0] UNLOCK_N    = 32'(UNLOCK_CNT);
  localparam logic [31:0] TIMEOUT_N   = 32'(TIMEOUT);
  localparam logic [5:0]  COARSE_GOOD = 6'd4;

  state_t     state_q, state_d;
  logic [5:0] good_q, good_d;
  logic [5:0] bad_q, bad_d;
  logic [9:0] timer_q, timer_d;
  logic       fail_d;

  logic [ERR_W-1:0] absErr;
  logic [31:0]      absExt;
  logic [5:0]       goodInc;
  logic [5:0]       badInc;
  logic [9:0]       timerInc;
  logic             timerHit;

  // Magnitude of the phase error. The most-negative code has no positive
  // counterpart, so it is clamped to the largest positive magnitude.
  always_comb begin
    absErr = '0;
    if (err[ERR_W-1]) begin
      if (err == {1'b1, {(ERR_W-1){1'b0}}}) begin
        absErr = {1'b0, {(ERR_W-1){1'b1}}};
      end else begin
        absErr = -err;
      end
    end else begin
      absErr = err;
    end
  end

  assign absExt = 32'(absErr);

  // Counters stick at all-ones instead of wrapping.
  assign goodInc  = (good_q  == 6'h3F)  ? good_q  : good_q  + 6'd1;
  assign badInc   = (bad_q   == 6'h3F)  ? bad_q   : bad_q   + 6'd1;
  assign timerInc = (timer_q == 10'h3FF) ? timer_q : timer_q + 10'd1;
  assign timerHit = (32'(timerInc) >= TIMEOUT_N);

  // Next-state logic. Priority within a cycle: enable, then reference
  // presence, then acquisition timeout, then error-driven transitions.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    timer_d = timer_q;
    fail_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      good_d  = '0;
      bad_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_ok) begin
            state_d = COARSE;
            good_d  = '0;
            bad_d   = '0;
            timer_d = '0;
          end
        end

        COARSE, FINE: begin
          if (!ref_ok) begin
            state_d = IDLE;
            good_d  = '0;
            bad_d   = '0;
            timer_d = '0;
          end else if (err_vld) begin
            if (timerHit) begin
              // Acquisition is taking too long: start over from coarse gain.
              state_d = COARSE;
              fail_d  = 1'b1;
              timer_d = '0;
              good_d  = '0;
            end else begin
              timer_d = timerInc;
              if (state_q == COARSE) begin
                if (absExt <= COARSE_LIM) begin
                  if (goodInc == COARSE_GOOD) begin
                    state_d = FINE;
                    good_d  = '0;
                  end else begin
                    good_d = goodInc;
                  end
                end else begin
                  good_d = '0;
                end
              end else begin
                if (absExt > COARSE_LIM) begin
                  state_d = COARSE;
                  good_d  = '0;
                end else if (absExt <= LOCK_LIM) begin
                  if (32'(goodInc) >= LOCK_N) begin
                    // Entering lock restarts the acquisition timer so a later
                    // unlock gets a full timeout budget.
                    state_d = LOCKED;
                    good_d  = '0;
                    bad_d   = '0;
                    timer_d = '0;
                  end else begin
                    good_d = goodInc;
                  end
                end else begin
                  good_d = '0;
                end
              end
            end
          end
        end

        LOCKED: begin
          if (!ref_ok) begin
`ifdef DPLL_HOLDOVER_EN
            state_d = HOLDOVER;
`else
            state_d = IDLE;
`endif
            good_d  = '0;
            bad_d   = '0;
            timer_d = '0;
          end else if (err_vld) begin
            if (absExt > LOCK_LIM) begin
              if (32'(badInc) >= UNLOCK_N) begin
                state_d = FINE;
                good_d  = '0;
                bad_d   = '0;
                timer_d = '0;
              end else begin
                bad_d = badInc;
              end
            end else begin
              bad_d = '0;
            end
          end
        end

        HOLDOVER: begin
`ifdef DPLL_HOLDOVER_EN
          if (ref_ok) begin
            state_d = FINE;
            good_d  = '0;
            bad_d   = '0;
            timer_d = '0;
          end
`else
          state_d = IDLE;
          good_d  = '0;
          bad_d   = '0;
          timer_d = '0;
`endif
        end

        default: begin
          state_d = IDLE;
          good_d  = '0;
          bad_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, counters and the per-state outputs, all registered. The outputs
  // are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      good_q   <= '0;
      bad_q    <= '0;
      timer_q  <= '0;
      acq_fail <= 1'b0;
      gain_sel <= 2'd0;
      dco_hold <= 1'b1;
      locked   <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      timer_q  <= timer_d;
      acq_fail <= fail_d;
      case (state_d)
        COARSE: begin
          gain_sel <= 2'd1;
          dco_hold <= 1'b0;
          locked   <= 1'b0;
        end
        FINE: begin
          gain_sel <= 2'd2;
          dco_hold <= 1'b0;
          locked   <= 1'b0;
        end
        LOCKED: begin
          gain_sel <= 2'd3;
          dco_hold <= 1'b0;
          locked   <= 1'b1;
        end
        default: begin
          gain_sel <= 2'd0;
          dco_hold <= 1'b1;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule
